signed_divider_16by8: RTL and testbench
=======================================

// Module: signed_divider_16by8
// PURPOSE
//  Iterative signed divider: the inverse of the 8x8 signed Dadda multiplier in execution_unit.
//  Divides a 16-bit signed dividend by an 8-bit signed divisor.
//  Returns a 16-bit quotient and a 16-bit remainder.
//  Radix-2 restoring algorithm on magnitudes, with sign correction at the end.
//  Valid/ready handshakes on both input and output.
//  Sits beside the multiplier in the execution unit. For any A,B: (A*B)/B == A, remainder 0.
// PARAMETERS
//  DIVIDEND_W  16  dividend, quotient and remainder width (signed)
//  DIVISOR_W    8  divisor width (signed); must be <= DIVIDEND_W
// PORTS
//  clk        in   1           rising-edge clock, single clock domain
//  reset      in   1           synchronous, active-high reset
//  in_valid   in   1           dividend/divisor valid
//  in_ready   out  1           divider can accept a new operation
//  dividend   in   DIVIDEND_W  signed dividend
//  divisor    in   DIVISOR_W   signed divisor
//  out_valid  out  1           quotient/remainder valid
//  out_ready  in   1           consumer accepts result
//  quotient   out  DIVIDEND_W  signed quotient, truncated toward zero
//  remainder  out  DIVIDEND_W  signed remainder; takes the sign of the dividend
//  div_zero   out  1           result came from a divide-by-zero
// BEHAVIOUR
//  Clock and reset: one clock (clk). Reset is synchronous and active-high.
//  Reset values: state=IDLE, out_valid=0, quotient=0, remainder=0, div_zero=0.
//   in_ready = (state==IDLE), so it reads 1 once the reset edge has been taken.
//  States: IDLE, CALC, FIX, DONE.
//  Accept: in_valid && in_ready at a rising edge. Operands are captured and the state is decided as follows.
//   divisor==0 -> DONE with quotient=all-ones (-1), remainder=dividend, div_zero=1.
//   dividend==most-negative && divisor==-1 -> DONE with quotient=dividend, remainder=0, div_zero=0.
//   Otherwise -> CALC. Load magnitudes |dividend| (DIVIDEND_W bits, unsigned) and |divisor| (DIVISOR_W+1 bits).
//   Record q_neg = sign(dividend)^sign(divisor) and r_neg = sign(dividend). Clear the partial remainder and the iteration counter.
//  CALC: exactly DIVIDEND_W cycles, one quotient bit per cycle, MSB first.
//   Shift the partial remainder left, bringing in the next dividend bit.
//   If the partial remainder >= |divisor|: subtract |divisor| and set the quotient bit to 1; otherwise set it to 0.
//   Partial remainder is DIVISOR_W+1 bits wide, so there is no overflow.
//   The counter leaves CALC to FIX after the cycle that produces the last bit.
//  FIX: 1 cycle.
//   quotient = q_neg ? -q_mag : q_mag.
//   remainder = r_neg ? -r_mag : r_mag (sign-extended to DIVIDEND_W).
//   Then go to DONE.
//  Latency, counted from the accept edge k:
//   Normal path: out_valid=1 after edge k+DIVIDEND_W+1 (edge k+17 at defaults).
//   Special cases: out_valid=1 after edge k+1.
//  DONE: out_valid=1 while in DONE. quotient, remainder and div_zero are held stable while out_valid && !out_ready.
//   out_valid && out_ready at an edge -> IDLE, out_valid=0. Outputs keep their last values.
//   in_ready is 0 in DONE; a new operation cannot be accepted on the same edge as the result is taken.
//  in_ready=0 in CALC, FIX and DONE. in_valid is ignored outside IDLE, and the operands need not be held after accept.
//  Reset during CALC, FIX or DONE: abort and return to the reset values on that edge. No partial result is ever presented.
//  Invariant for all non-div-zero results: quotient*divisor + remainder == dividend, and |remainder| < |divisor|.
//  Divisor -128 is handled through the DIVISOR_W+1-bit magnitude (|divisor| = 128).
// TESTING
//  100 / 7 -> quotient=14, remainder=2, div_zero=0; out_valid exactly 17 cycles after accept.
//  -100 / 7 -> quotient=-14, remainder=-2. 100 / -7 -> quotient=-14, remainder=2.
//  16384 / -128 (the product -128*-128) -> quotient=-128, remainder=0.
//  1234 / 0 -> quotient=16'hFFFF, remainder=1234, div_zero=1, 1-cycle latency.
//  -32768 / -1 -> quotient=16'h8000, remainder=0, div_zero=0, 1-cycle latency.
//  Backpressure and reset:
//   Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; accept occurs on the first edge with out_ready=1.
//   Assert reset at CALC cycle 8 -> IDLE and in_ready=1 next cycle, out_valid never pulses.
//   Random operands checked against the invariant.

Source files
------------

// File: rtl/signed_divider_16by8.sv
// rtl/signed_divider_16by8.sv - iterative radix-2 restoring signed divider, 16-bit dividend by 8-bit divisor
module signed_divider_16by8 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVIDEND_W-1:0] remainder,
    output logic                  div_zero
);

    localparam int PR_W  = DIVISOR_W + 1;
    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] MOST_NEG = {1'b1, {(DIVIDEND_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state_q;
    logic [DIVIDEND_W-1:0]   a_q;
    logic [PR_W-1:0]         b_q;
    logic [PR_W-1:0]         pr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    q_neg_q;
    logic                    r_neg_q;
    logic                    special_q;
    logic                    zero_q;
    logic                    out_valid_q;
    logic [DIVIDEND_W-1:0]   quotient_q;
    logic [DIVIDEND_W-1:0]   remainder_q;
    logic                    div_zero_q;

    logic [DIVIDEND_W-1:0]   dividend_mag;
    logic [PR_W-1:0]         divisor_ext;
    logic [PR_W-1:0]         divisor_mag;
    logic [PR_W-1:0]         pr_shift;
    logic [PR_W-1:0]         pr_diff;
    logic                    pr_ge;
    logic [PR_W-1:0]         pr_d;
    logic [DIVIDEND_W-1:0]   r_ext;
    logic                    is_zero;
    logic                    is_ovf;

    assign dividend_mag = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    assign divisor_ext  = {divisor[DIVISOR_W-1], divisor};
    assign divisor_mag  = divisor[DIVISOR_W-1] ? -divisor_ext : divisor_ext;
    assign is_zero      = (divisor == '0);
    assign is_ovf       = (dividend == MOST_NEG) && (divisor == '1);

    // Partial remainder stays below |divisor| <= 2^(DIVISOR_W-1), so its MSB is never shifted out.
    assign pr_shift = {pr_q[DIVISOR_W-1:0], a_q[DIVIDEND_W-1]};
    assign pr_diff  = pr_shift - b_q;
    assign pr_ge    = (pr_shift >= b_q);
    assign pr_d     = pr_ge ? pr_diff : pr_shift;
    assign r_ext    = DIVIDEND_W'(pr_q);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            pr_q        <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            special_q   <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pr_q    <= '0;
                        cnt_q   <= '0;
                        q_neg_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                        r_neg_q <= dividend[DIVIDEND_W-1];
                        zero_q  <= is_zero;
                        // Special cases pass through FIX so their result lands one edge after accept.
                        if (is_zero || is_ovf) begin
                            a_q       <= dividend;
                            special_q <= 1'b1;
                            state_q   <= FIX;
                        end else begin
                            a_q       <= dividend_mag;
                            b_q       <= divisor_mag;
                            special_q <= 1'b0;
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    pr_q  <= pr_d;
                    a_q   <= {a_q[DIVIDEND_W-2:0], pr_ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (special_q) begin
                        quotient_q  <= zero_q ? '1 : a_q;
                        remainder_q <= zero_q ? a_q : '0;
                        div_zero_q  <= zero_q;
                    end else begin
                        quotient_q  <= q_neg_q ? -a_q : a_q;
                        remainder_q <= r_neg_q ? -r_ext : r_ext;
                        div_zero_q  <= 1'b0;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_16by8.sv
// tb/tb_signed_divider_16by8.sv - directed and random checks of signed_divider_16by8
module tb_signed_divider_16by8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] r_q;
    logic [15:0] r_r;
    logic        r_dz;
    int          r_lat;

    signed_divider_16by8 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [15:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 8'h00;
        r_lat    = 0;
        while (!out_valid && r_lat < 40) begin
            @(posedge clk);
            #1;
            r_lat++;
        end
        r_q  = quotient;
        r_r  = remainder;
        r_dz = div_zero;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++;
        if (quotient !== 16'h0) $display("FAIL reset_quotient got=%h exp=0000", quotient); else n_pass++;
        n_checks++;
        if (remainder !== 16'h0) $display("FAIL reset_remainder got=%h exp=0000", remainder); else n_pass++;
        n_checks++;
        if (div_zero !== 1'b0) $display("FAIL reset_div_zero got=%b exp=0", div_zero); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int ta [9] = '{100, -100, 100, 16384, -100, 7, -32768, -32768, 32767};
        int tb [9] = '{7, 7, -7, -128, -7, 100, -128, 127, -128};
        int eq [9] = '{14, -14, -14, -128, 14, 0, 256, -258, -255};
        int er [9] = '{2, -2, 2, 0, -2, 7, 0, -2, 127};
        for (int i = 0; i < 9; i++) begin
            run_op(16'(ta[i]), 8'(tb[i]));
            n_checks++;
            if (r_q !== 16'(eq[i]) || r_r !== 16'(er[i]) || r_dz !== 1'b0)
                $display("FAIL basic_%0d_result got q=%h r=%h dz=%b exp q=%h r=%h dz=0",
                         i, r_q, r_r, r_dz, 16'(eq[i]), 16'(er[i]));
            else n_pass++;
            n_checks++;
            if (r_lat !== 17) $display("FAIL basic_%0d_latency got=%0d exp=17", i, r_lat); else n_pass++;
            take_result();
        end
    endtask

    task automatic test_special();
        logic [15:0] ta [3] = '{16'd1234, 16'h8000, 16'hFFFB};
        logic [7:0]  tb [3] = '{8'h00, 8'hFF, 8'h00};
        logic [15:0] eq [3] = '{16'hFFFF, 16'h8000, 16'hFFFF};
        logic [15:0] er [3] = '{16'd1234, 16'h0000, 16'hFFFB};
        logic        ez [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i]);
            n_checks++;
            if (r_q !== eq[i] || r_r !== er[i] || r_dz !== ez[i])
                $display("FAIL special_%0d_result got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
                         i, r_q, r_r, r_dz, eq[i], er[i], ez[i]);
            else n_pass++;
            n_checks++;
            if (r_lat !== 1) $display("FAIL special_%0d_latency got=%0d exp=1", i, r_lat); else n_pass++;
            take_result();
        end
    endtask

    task automatic test_backpressure();
        run_op(16'd100, 8'd7);
        n_checks++;
        if (r_q !== 16'd14 || r_r !== 16'd2 || r_dz !== 1'b0)
            $display("FAIL bp_result got q=%h r=%h dz=%b exp q=000e r=0002 dz=0", r_q, r_r, r_dz);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'd5;
            divisor  = 8'd1;
            @(posedge clk);
            #1;
            n_checks++;
            if (quotient !== 16'd14 || remainder !== 16'd2 || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold_%0d got q=%h r=%h ov=%b ir=%b exp q=000e r=0002 ov=1 ir=0",
                         i, quotient, remainder, out_valid, in_ready);
            else n_pass++;
        end
        in_valid = 1'b0;
        take_result();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'd14)
            $display("FAIL bp_release got ov=%b ir=%b q=%h exp ov=0 ir=1 q=000e", out_valid, in_ready, quotient);
        else n_pass++;
        run_op(16'hFF9C, 8'd7);
        n_checks++;
        if (r_q !== 16'hFFF2 || r_r !== 16'hFFFE || r_lat !== 17)
            $display("FAIL bp_followup got q=%h r=%h lat=%0d exp q=fff2 r=fffe lat=17", r_q, r_r, r_lat);
        else n_pass++;
        take_result();
    endtask

    task automatic test_reset_midcalc();
        bit seen_valid = 1'b0;
        in_valid = 1'b1;
        dividend = 16'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'h0)
            $display("FAIL midcalc_reset got ir=%b ov=%b q=%h exp ir=1 ov=0 q=0000", in_ready, out_valid, quotient);
        else n_pass++;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0) $display("FAIL midcalc_no_pulse got=%b exp=0", seen_valid); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midcalc_idle got=%b exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            int          sa, sb, eq, er, rq, rr;
            a = 16'($urandom_range(0, 65535));
            b = 8'($urandom_range(0, 255));
            if (b == 8'h00) b = 8'h01;
            if (a == 16'h8000 && b == 8'hFF) b = 8'h03;
            sa = int'($signed(a));
            sb = int'($signed(b));
            eq = sa / sb;
            er = sa % sb;
            run_op(a, b);
            rq = int'($signed(r_q));
            rr = int'($signed(r_r));
            n_checks++;
            if (r_q !== 16'(eq) || r_r !== 16'(er) || r_dz !== 1'b0 || r_lat !== 17 ||
                rq * sb + rr != sa || (rr < 0 ? -rr : rr) >= (sb < 0 ? -sb : sb))
                $display("FAIL random_%0d a=%0d b=%0d got q=%0d r=%0d dz=%b lat=%0d exp q=%0d r=%0d",
                         i, sa, sb, rq, rr, r_dz, r_lat, eq, er);
            else n_pass++;
            take_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_backpressure();
        test_reset_midcalc();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
